// File: rtl/idc_stream.sv
// idc_stream: serial identity-code checker and check-digit generator.
// One letter-code beat starts a frame, followed by decimal digit beats.
// A weighted modulo-10 checksum is accumulated across the frame.
// One cycle after the final beat, a single result pulse reports:
//   - legality of the frame,
//   - the error class,
//   - in generate mode, the check digit that would make the frame legal.
module idc_stream #(
    parameter int NUM_DIGITS = 9,
    parameter int LETTER_MIN = 10,
    parameter int LETTER_MAX = 35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_mode,
    input  logic       in_abort,
    input  logic [5:0] in_id,
    output logic       out_valid,
    output logic       out_legal_id,
    output logic [1:0] out_err,
    output logic [3:0] out_check_digit,
    output logic       busy
);

    localparam logic [3:0] ND   = 4'(NUM_DIGITS);
    localparam logic [5:0] LMIN = 6'(LETTER_MIN);
    localparam logic [5:0] LMAX = 6'(LETTER_MAX);

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LETTER = 2'd1;
    localparam logic [1:0] ERR_DIGIT  = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        DIGITS = 1'b1
    } state_t;

    // Reduce a partial sum (at most 141) to its residue mod 10.
    function automatic logic [3:0] mod10(input logic [7:0] v);
        return 4'(v % 8'd10);
    endfunction

    // Check digit that brings a residue back to zero.
    function automatic logic [3:0] complement10(input logic [3:0] a);
        return (a == 4'd0) ? 4'd0 : 4'(4'd10 - a);
    endfunction

    state_t     state;
    logic       mode_q;
    logic [3:0] acc_q;
    logic [3:0] cnt_q;
    logic [1:0] err_q;

    logic       valid_p1;
    logic       legal_p1;
    logic [1:0] err_p1;
    logic [3:0] cd_p1;

    // Letter-beat contributions.
    logic [5:0] letter_tens;
    logic [5:0] letter_ones;
    logic [3:0] letter_acc;
    logic       letter_bad;

    // Digit-beat contributions.
    logic [3:0] beat_k;
    logic [3:0] weight;
    logic [3:0] k_total;
    logic       digit_ok;
    logic [7:0] digit_prod;
    logic [3:0] acc_nxt;
    logic [1:0] err_nxt;
    logic       last_beat;

    // Letter split into tens/ones; the ones digit carries weight NUM_DIGITS.
    always_comb begin
        letter_tens = in_id / 6'd10;
        letter_ones = in_id % 6'd10;
        letter_acc  = mod10(8'(letter_tens) + 8'(letter_ones) * 8'(ND));
        letter_bad  = (in_id < LMIN) || (in_id > LMAX);
    end

    // Digit beat k weighs NUM_DIGITS-k, except the final check-mode beat which weighs 1.
    // An out-of-range digit contributes nothing; only the first error is kept.
    always_comb begin
        beat_k     = cnt_q + 4'd1;
        weight     = (beat_k < ND) ? 4'(ND - beat_k) : 4'd1;
        k_total    = mode_q ? 4'(ND - 4'd1) : ND;
        digit_ok   = (in_id <= 6'd9);
        digit_prod = digit_ok ? 8'(in_id[3:0]) * 8'(weight) : 8'd0;
        acc_nxt    = mod10(8'(acc_q) + digit_prod);
        err_nxt    = (err_q == ERR_NONE && !digit_ok) ? ERR_DIGIT : err_q;
        last_beat  = (beat_k == k_total);
    end

    // Frame FSM plus the one-cycle result register; results default to 0 every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            acc_q    <= 4'd0;
            cnt_q    <= 4'd0;
            err_q    <= ERR_NONE;
            valid_p1 <= 1'b0;
            legal_p1 <= 1'b0;
            err_p1   <= ERR_NONE;
            cd_p1    <= 4'd0;
        end else begin
            valid_p1 <= 1'b0;
            legal_p1 <= 1'b0;
            err_p1   <= ERR_NONE;
            cd_p1    <= 4'd0;
            case (state)
                IDLE: begin
                    if (in_valid && !in_abort) begin
                        state  <= DIGITS;
                        mode_q <= in_mode;
                        acc_q  <= letter_acc;
                        cnt_q  <= 4'd0;
                        err_q  <= letter_bad ? ERR_LETTER : ERR_NONE;
                    end
                end
                DIGITS: begin
                    if (in_abort) begin
                        state <= IDLE;
                        acc_q <= 4'd0;
                        cnt_q <= 4'd0;
                        err_q <= ERR_NONE;
                    end else if (in_valid) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            acc_q    <= 4'd0;
                            cnt_q    <= 4'd0;
                            err_q    <= ERR_NONE;
                            valid_p1 <= 1'b1;
                            err_p1   <= err_nxt;
                            if (err_nxt != ERR_NONE) begin
                                legal_p1 <= 1'b0;
                                cd_p1    <= 4'd0;
                            end else if (mode_q) begin
                                legal_p1 <= 1'b1;
                                cd_p1    <= complement10(acc_nxt);
                            end else begin
                                legal_p1 <= (acc_nxt == 4'd0);
                                cd_p1    <= 4'd0;
                            end
                        end else begin
                            acc_q <= acc_nxt;
                            err_q <= err_nxt;
                            cnt_q <= beat_k;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid       = valid_p1;
    assign out_legal_id    = legal_p1;
    assign out_err         = err_p1;
    assign out_check_digit = cd_p1;
    assign busy            = (state == DIGITS);

endmodule
